l2_l1_responder: RTL

- L2-side responder for the L1 data-cache miss interface: services line refill (read) and dirty-line write-back (write) requests from the L1 D-cache controller.
- Converts each request into a burst of single-beat transactions on the backing-memory port.
- Returns one ready pulse per completed request.
- Sits between the L1 D-cache controller/data array and the memory/bus interface.

---
 rtl/l2_l1_responder_if.sv | 35 +++
 rtl/l2_l1_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/l2_l1_responder_if.sv
// L1 miss-interface and backing-memory beat port bundled for the L2 responder.
// master = L1 controller plus memory side (environment), slave = the responder.
interface l2_l1_responder_if #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned MEM_W  = 128,
    parameter int unsigned ADDR_W = 32
) ();
    logic              read_L1_L2;
    logic              write_L1_L2;
    logic [4:0]        index_L1_L2;
    logic [20:0]       tag_L1_L2;
    logic [20:0]       write_tag_L1_L2;
    logic [LINE_W-1:0] wdata_L1_L2;
    logic              ready_L2_L1;
    logic [LINE_W-1:0] rdata_L2_L1;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic              mem_ack;
    logic [MEM_W-1:0]  mem_rdata;

    modport master (
        output read_L1_L2, write_L1_L2, index_L1_L2, tag_L1_L2, write_tag_L1_L2, wdata_L1_L2,
        output mem_ack, mem_rdata,
        input  ready_L2_L1, rdata_L2_L1, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  read_L1_L2, write_L1_L2, index_L1_L2, tag_L1_L2, write_tag_L1_L2, wdata_L1_L2,
        input  mem_ack, mem_rdata,
        output ready_L2_L1, rdata_L2_L1, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_l1_responder.sv
// L2 responder for L1 D-cache refills/write-backs, split into MEM_W beats on the memory port.
// Define L2_WB_POSTED_EN to acknowledge write-backs at once and drain them from a posted buffer.
module l2_l1_responder #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned MEM_W  = 128,
    parameter int unsigned ADDR_W = 32
) (
    input logic              clk,
    input logic              rst,
    l2_l1_responder_if.slave bus
);
    localparam int unsigned BEATS   = LINE_W / MEM_W;
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BYTE_SH = $clog2(MEM_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWb    = 3'd1;
    localparam logic [2:0] StRd    = 3'd2;
    localparam logic [2:0] StResp  = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [CNT_W-1:0]             beat_q, beat_d, beat_inc;
    logic [20:0]                  tag_q, tag_d;
    logic [4:0]                   index_q, index_d;
    logic [BEATS-1:0][MEM_W-1:0]  line_q, line_d;
    logic                         ready_q, ready_d;
    logic [BEATS-1:0][MEM_W-1:0]  rdata_q, rdata_d;
    logic                         req_q, req_d;
    logic                         we_q, we_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [MEM_W-1:0]             wdata_q, wdata_d;

    logic pb_free;
    logic start_wr;
    logic start_rd;
    logic beat_ack;
    logic last_ack;

    // Line base {tag, index} followed by the byte offset of the beat within the 64-byte line.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [20:0]      tag,
                                                    input logic [4:0]       idx,
                                                    input logic [CNT_W-1:0] beat);
        logic [5:0] off;
        off = 6'(beat) << BYTE_SH;
        return ADDR_W'({tag, idx, off});
    endfunction

`ifdef L2_WB_POSTED_EN
    localparam bit POSTED = 1'b1;

    // Posted-buffer FSM: busy from write acceptance until its last beat is acked.
    logic pb_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pb_busy_q <= 1'b0;
        end else if (start_wr) begin
            pb_busy_q <= 1'b1;
        end else if (last_ack && we_q) begin
            pb_busy_q <= 1'b0;
        end
    end

    assign pb_free = !pb_busy_q;
`else
    localparam bit POSTED = 1'b0;

    assign pb_free = 1'b1;
`endif

    // Write wins over a simultaneous read; both wait while a posted line is still draining.
    assign start_wr = (state_q == StIdle) && bus.write_L1_L2 && pb_free;
    assign start_rd = (state_q == StIdle) && bus.read_L1_L2 && !bus.write_L1_L2 && pb_free;
    assign beat_ack = req_q && bus.mem_ack;
    assign last_ack = beat_ack && (beat_q == LAST);
    assign beat_inc = beat_q + 1'b1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        index_d = index_q;
        line_d  = line_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (beat_ack) begin
            if (!we_q) begin
                rdata_d[beat_q] = bus.mem_rdata;
            end
            if (beat_q == LAST) begin
                beat_d = '0;
                req_d  = 1'b0;
                we_d   = 1'b0;
            end else begin
                beat_d  = beat_inc;
                addr_d  = beat_addr(tag_q, index_q, beat_inc);
                wdata_d = line_q[beat_inc];
            end
        end

        case (state_q)
            StIdle: begin
                if (start_wr) begin
                    tag_d   = bus.write_tag_L1_L2;
                    index_d = bus.index_L1_L2;
                    line_d  = bus.wdata_L1_L2;
                    beat_d  = '0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = beat_addr(bus.write_tag_L1_L2, bus.index_L1_L2, '0);
                    wdata_d = bus.wdata_L1_L2[MEM_W-1:0];
                    state_d = POSTED ? StResp : StWb;
                    ready_d = POSTED;
                end else if (start_rd) begin
                    tag_d   = bus.tag_L1_L2;
                    index_d = bus.index_L1_L2;
                    beat_d  = '0;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = beat_addr(bus.tag_L1_L2, bus.index_L1_L2, '0);
                    state_d = StRd;
                end
            end
            StWb, StRd: begin
                if (last_ack) begin
                    ready_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StDrain;
            end
            StDrain: begin
                // L1 drops its request a cycle after ready; a stale level must not restart.
                if (!bus.read_L1_L2 && !bus.write_L1_L2) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            tag_q   <= '0;
            index_q <= '0;
            line_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.ready_L2_L1 = ready_q;
    assign bus.rdata_L2_L1 = rdata_q;
    assign bus.mem_req     = req_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
endmodule
